// File: rtl/if_id_pipe_pkg.sv
// if_id_pipe_pkg: shared reset/word constants and slot update actions for the IF/ID pipeline register.
package if_id_pipe_pkg;
   localparam logic        RST_ENA       = 1'b1;
   localparam int          INST_ADDR_BUS = 32;
   localparam int          INST_BUS      = 32;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic [31:0] NOP_INST_WORD = ZERO_WORD;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_LOAD_IN,
      ACT_LOAD_SKID,
      ACT_DRAIN,
      ACT_FLUSH
   } slot_act_e;
endpackage

// File: rtl/if_id_skid.sv
// if_id_skid: one-entry skid buffer catching an offer that arrives while decode stalls.
module if_id_skid
   import if_id_pipe_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int INST_W = INST_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [INST_W-1:0] push_inst,
   output logic              valid,
   output logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] inst
);
   always_ff @(posedge clk) begin
      if (rst == RST_ENA || flush) begin
         valid <= 1'b0;
         pc    <= ADDR_W'(ZERO_WORD);
         inst  <= INST_W'(ZERO_WORD);
      end else if (push) begin
         valid <= 1'b1;
         pc    <= push_pc;
         inst  <= push_inst;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF->ID pipeline register with valid/ready, stall, flush and NOP bubbles.
// Define IF_ID_SKID_EN to add a one-entry skid buffer and a registered if_ready.
module if_id_pipe
   import if_id_pipe_pkg::*;
#(
   parameter int                ADDR_W   = INST_ADDR_BUS,
   parameter int                INST_W   = INST_BUS,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_WORD)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   input  logic              if_valid,
   output logic              if_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              id_valid,
   input  logic              id_ready,
   input  logic              flush
);
   logic              take;
   logic              acc;
   logic              skid_valid;
   logic [ADDR_W-1:0] skid_pc;
   logic [INST_W-1:0] skid_inst;
   slot_act_e         act;

   assign take = ~id_valid | id_ready;
   assign acc  = if_valid & if_ready;

`ifdef IF_ID_SKID_EN
   assign if_ready = flush | ~skid_valid;

   if_id_skid #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (acc & ~take & ~flush),
      .pop       (take & skid_valid),
      .push_pc   (if_pc),
      .push_inst (if_inst),
      .valid     (skid_valid),
      .pc        (skid_pc),
      .inst      (skid_inst)
   );
`else
   assign if_ready   = flush | ~id_valid | id_ready;
   assign skid_valid = 1'b0;
   assign skid_pc    = '0;
   assign skid_inst  = '0;
`endif

   // A held skid entry is older than any offer, so it always refills the slot first.
   always_comb
      act = flush             ? ACT_FLUSH     :
            take & skid_valid ? ACT_LOAD_SKID :
            take & acc        ? ACT_LOAD_IN   :
            take              ? ACT_DRAIN     : ACT_HOLD;

   always_ff @(posedge clk) begin
      if (rst == RST_ENA) begin
         id_pc    <= ADDR_W'(ZERO_WORD);
         id_inst  <= INST_W'(ZERO_WORD);
         id_valid <= 1'b0;
      end else begin
         case (act)
            ACT_FLUSH: begin
               id_pc    <= ADDR_W'(ZERO_WORD);
               id_inst  <= NOP_INST;
               id_valid <= 1'b0;
            end
            ACT_LOAD_SKID: begin
               id_pc    <= skid_pc;
               id_inst  <= skid_inst;
               id_valid <= 1'b1;
            end
            ACT_LOAD_IN: begin
               id_pc    <= if_pc;
               id_inst  <= if_inst;
               id_valid <= 1'b1;
            end
            ACT_DRAIN: begin
               id_inst  <= NOP_INST;
               id_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: scenario tasks plus a scoreboard monitor for if_id_pipe (either build).
module tb_if_id_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_pc = '0;
   logic [31:0] if_inst = '0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic        flush = 1'b0;

   int total = 0;
   int bad = 0;
   logic [63:0] sb_q[$];

`ifdef IF_ID_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   if_id_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_valid (if_valid),
      .if_ready (if_ready),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_valid (id_valid),
      .id_ready (id_ready),
      .flush    (flush)
   );

   always #5 clk = ~clk;

   // Scoreboard: accepted offers are queued in order and must emerge on transfer out.
   always @(negedge clk) begin
      logic [63:0] exp;
      logic        exp_ready;
      if (rst || flush) begin
         sb_q.delete();
      end else begin
         exp_ready = SKID ? (sb_q.size() < 2) : (sb_q.size() == 0 || id_ready);
         total++;
         if (id_valid !== (sb_q.size() != 0)) begin
            bad++;
            $display("FAIL sb_valid: got %b want %b at %0t", id_valid, sb_q.size() != 0, $time);
         end
         total++;
         if (if_ready !== exp_ready) begin
            bad++;
            $display("FAIL sb_ready: got %b want %b at %0t", if_ready, exp_ready, $time);
         end
         if (id_valid && id_ready && sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            total++;
            if ({id_pc, id_inst} !== exp) begin
               bad++;
               $display("FAIL sb_data: got %h/%h want %h/%h", id_pc, id_inst, exp[63:32], exp[31:0]);
            end
         end
         if (if_valid && if_ready) sb_q.push_back({if_pc, if_inst});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      offer(1'b1, 32'hDEAD_0000, 32'hFFFF_FFFF);
      id_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      offer(1'b0, '0, '0);
      @(negedge clk);
      total++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || if_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset: got v=%b pc=%h inst=%h rdy=%b want 0/0/0/1", id_valid, id_pc, id_inst, if_ready);
      end
      tick();
   endtask

   task automatic test_stream;
      logic [31:0] pcs[3];
      pcs = '{32'h100, 32'h104, 32'h108};
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) offer(1'b1, pcs[i], 32'hA000_0000 | pcs[i]);
         else offer(1'b0, '0, '0);
         @(negedge clk);
         if (i > 0) begin
            total++;
            if (id_valid !== 1'b1 || id_pc !== pcs[i-1] || id_inst !== (32'hA000_0000 | pcs[i-1])) begin
               bad++;
               $display("FAIL stream%0d: got v=%b pc=%h inst=%h want pc=%h", i, id_valid, id_pc, id_inst, pcs[i-1]);
            end
         end
         tick();
      end
   endtask

   task automatic test_bubble;
      offer(1'b0, '0, '0);
      id_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
            bad++;
            $display("FAIL bubble%0d: got v=%b inst=%h want 0/0", i, id_valid, id_inst);
         end
         tick();
      end
   endtask

   task automatic test_stall;
      id_ready = 1'b1;
      offer(1'b1, 32'h200, 32'h8C22_0000);
      tick();
      id_ready = 1'b0;
      offer(1'b1, 32'h204, 32'h1111_2222);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'h8C22_0000) begin
            bad++;
            $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h want 1/200/8c220000", i, id_valid, id_pc, id_inst);
         end
         total++;
         if (if_ready !== (SKID && i == 0)) begin
            bad++;
            $display("FAIL stall_ready%0d: got %b want %b", i, if_ready, SKID && i == 0);
         end
         tick();
      end
      id_ready = 1'b1;
      @(negedge clk);
      total++;
      if (if_ready !== !SKID) begin
         bad++;
         $display("FAIL stall_release_ready: got %b want %b", if_ready, !SKID);
      end
      tick();
      offer(1'b0, '0, '0);
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h204 || id_inst !== 32'h1111_2222) begin
         bad++;
         $display("FAIL stall_next: got v=%b pc=%h inst=%h want 1/204/11112222", id_valid, id_pc, id_inst);
      end
      tick();
      tick();
   endtask

   task automatic test_flush;
      id_ready = 1'b1;
      offer(1'b1, 32'h300, 32'h3333_0000);
      tick();
      id_ready = 1'b0;
      offer(1'b1, 32'h304, 32'h3333_0004);
      tick();
      offer(1'b1, 32'h308, 32'h3333_0008);
      flush = 1'b1;
      @(negedge clk);
      total++;
      if (if_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_ready: got %b want 1", if_ready);
      end
      tick();
      flush = 1'b0;
      offer(1'b0, '0, '0);
      id_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (id_valid !== 1'b0 || id_inst !== 32'h0 || (i == 0 && id_pc !== 32'h0)) begin
            bad++;
            $display("FAIL flush%0d: got v=%b pc=%h inst=%h want 0/0/0", i, id_valid, id_pc, id_inst);
         end
         tick();
      end
   endtask

   task automatic test_simultaneous;
      id_ready = 1'b0;
      offer(1'b1, 32'h3F0, 32'h5555_5555);
      tick();
      rst = 1'b1;
      flush = 1'b1;
      offer(1'b1, 32'h400, 32'h4444_4444);
      tick();
      rst = 1'b0;
      flush = 1'b0;
      offer(1'b0, '0, '0);
      @(negedge clk);
      total++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || if_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_flush: got v=%b pc=%h inst=%h rdy=%b want 0/0/0/1", id_valid, id_pc, id_inst, if_ready);
      end
      offer(1'b1, 32'h500, 32'h5000_0000);
      tick();
      id_ready = 1'b1;
      flush = 1'b1;
      offer(1'b1, 32'h504, 32'h5000_0004);
      tick();
      flush = 1'b0;
      offer(1'b0, '0, '0);
      @(negedge clk);
      total++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
         bad++;
         $display("FAIL flush_drain: got v=%b pc=%h inst=%h want 0/0/0", id_valid, id_pc, id_inst);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      int n;
      for (int i = 0; i < 60; i++) begin
         offer(1'($urandom_range(0, 3) != 0), $urandom, $urandom);
         id_ready = 1'($urandom_range(0, 2) != 0);
         tick();
      end
      offer(1'b0, '0, '0);
      id_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 10) begin
         tick();
         n++;
      end
      @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain: %0d entries left want 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_bubble();
      test_stall();
      test_flush();
      test_simultaneous();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised IF→ID pipeline register with valid/ready handshake, stall and flush. It is the next generation of the plain IF/ID latch. It sits between the fetch stage and the decode stage. It carries the fetched PC and instruction forward and holds them while decode stalls. It converts squashed or empty slots into NOP bubbles (all-zero instruction) so decode never needs a separate kill path.

## Interface
Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- NOP_INST, 0 (ZeroWord), instruction value presented on `id_inst` for bubbles

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset (`RstEna` = 1); sampled on the rising edge of `clk`
- if_pc  in  ADDR_W  fetch-stage PC
- if_inst  in  INST_W  fetch-stage instruction
- if_valid  in  1  fetch offers `if_pc`/`if_inst` this cycle
- if_ready  out  1  register accepts the offer this cycle
- id_pc  out  ADDR_W  decode-stage PC
- id_inst  out  INST_W  decode-stage instruction; NOP_INST when `id_valid`=0
- id_valid  out  1  decode slot holds a live instruction
- id_ready  in  1  decode consumes the slot this cycle (0 = decode stall)
- flush  in  1  squash everything held and the current offer (branch/exception redirect)

## Operation
- Transfer in: `if_valid & if_ready`. Transfer out: `id_valid & id_ready`.
- Output slot update priority: rst > flush > load > hold.
- Load: the slot takes `if_pc`/`if_inst` and sets `id_valid`=1 when the slot is empty or drains this cycle.
- Hold: when `id_valid`=1 and `id_ready`=0, `id_pc`/`id_inst` stay bit-stable.
- Drain without new input: `id_valid`←0, `id_inst`←NOP_INST. `id_pc` keeps its last value; it is don't-care while invalid.
- Flush:
  - next cycle `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0, skid entry cleared.
  - `if_ready`=1 during flush; the offer is consumed and dropped.
  - flush and rst together behave as rst.
- Ordering: instructions leave in acceptance order. None is duplicated or lost except those dropped by flush.

## Timing
- Reset values: `id_pc`=0, `id_inst`=0, `id_valid`=0, skid empty, `if_ready`=1 in the first cycle after reset.
- Latency: one cycle. An offer accepted at edge N appears on `id_*` after edge N.
- Throughput: one instruction per cycle when `id_ready`=1 continuously.
- Without skid: `if_ready = flush | ~id_valid | id_ready`. This is a combinational path from `id_ready`.
- With skid: `if_ready = flush | ~skid_valid`. This is a registered path; there is no combinational `id_ready`→`if_ready` path.
- Stall during an offer (skid build): the offer goes to the skid entry. The next cycle `if_ready`=0.
- When the output drains, the skid entry moves to the output in that same edge. A simultaneous new offer is not accepted, because `if_ready` was 0.
- Mid-operation reset: all state is discarded on the edge. There is no partial transfer.

## Configuration
- `IF_ID_SKID_EN` defined:
  - adds a one-entry skid buffer;
  - `if_ready` is a registered signal;
  - the block can hold 2 instructions.
- Undefined:
  - single slot;
  - `if_ready` depends combinationally on `id_ready`;
  - capacity is 1.
- Functional ordering and flush semantics are identical in both builds.

## Structure
- `define.v` holds `RstEna`, `ZeroWord`, `InstAddrBus`, `InstBus`, and a new `NopInst` define. Parameter defaults derive from these.
- One sub-module is natural: `if_id_skid`. It holds the skid entry: storage, valid bit, flush clear. It is instantiated only under `IF_ID_SKID_EN`.

## Test plan
- Reset: assert rst 2 cycles with `if_valid`=1 → `id_valid`=0, `id_pc`=0, `id_inst`=0, `if_ready`=1 after release.
- Streaming: offer PCs 0x100, 0x104, 0x108 with `id_ready`=1 → they appear one cycle later, back-to-back, in order.
- Stall: hold `id_ready`=0 for 3 cycles while 0x200/0x8C220000 is in the slot → outputs bit-stable.
  - Without skid, `if_ready`=0.
  - With skid, the next offer 0x204 is captured and 0x204 emerges right after 0x200 on release.
- Flush: flush while the slot holds 0x300 (and skid holds 0x304) with a 0x308 offer → next cycle `id_valid`=0, `id_inst`=0, `id_pc`=0. None of the three ever appears.
- Simultaneous: `rst`=1 and `flush`=1 with `if_valid`=1 → reset values; flush and drain on the same edge → flush wins.
- Bubble: `if_valid`=0 for 2 cycles with `id_ready`=1 → `id_valid`=0, `id_inst`=NOP_INST in those cycles.
